// File: rtl/data_unpack_pkg.sv
// rtl/data_unpack_pkg.sv - shared widths, counts and state encoding for the word-to-packet unpacker
package data_unpack_pkg;

    localparam int WORD_W       = 32;
    localparam int PKT_W        = 7;
    localparam int CNT_W        = 5;
    localparam int FIFO_DEPTH   = 4;
    localparam int INIT_COUNT   = 6;
    localparam int REFILL_COUNT = 25;
    localparam int ENTRY_W      = WORD_W + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/data_unpack_fifo.sv
// rtl/data_unpack_fifo.sv - small word FIFO holding {last, word}; flush empties it in one cycle
module data_unpack_fifo
    import data_unpack_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] push_data_i,
    input  logic               pop_i,
    output logic [ENTRY_W-1:0] head_o,
    output logic               empty_o,
    output logic               full_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_FW = $clog2(FIFO_DEPTH + 1);

    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_FW-1:0]  cnt_q, cnt_d;
    logic               do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_FW'(FIFO_DEPTH));
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push_i && !full_o && !flush_i;
        do_pop   = pop_i && !empty_o && !flush_i;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        cnt_d    = cnt_q + CNT_FW'(do_push) - CNT_FW'(do_pop);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/data_unpack_ctrl.sv
// rtl/data_unpack_ctrl.sv - sequences an external free-running 7-bit unpack datapath from a word FIFO
module data_unpack_ctrl
    import data_unpack_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [WORD_W-1:0] in_word,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [WORD_W-1:0] dp_data_in,
    output logic              dp_data_rst,
    output logic              dp_data_load,
    output logic              dp_overflow_load,
    output logic              dp_count_set,
    input  logic [CNT_W-1:0]  dp_count,
    output logic              pkt_valid,
    output logic              pkt_first,
    output logic              pkt_last,
    output logic              frame_done,
    output logic              underrun,
    output logic [2:0]        drop_bits
);

    state_e             state_q, state_d;
    logic               last_q, last_d;
    logic               first_q, first_d;
    logic               fifo_empty, fifo_full, fifo_pop, fifo_push;
    logic [ENTRY_W-1:0] fifo_head;
    logic               refill_pt;

    assign in_ready   = rst_n && !fifo_full && !flush;
    assign fifo_push  = in_valid && in_ready;
    assign dp_data_in = fifo_head[WORD_W-1:0];
    // At or past this count the current word has fewer than 7 unread bits left.
    assign refill_pt  = (dp_count >= CNT_W'(REFILL_COUNT));

    data_unpack_fifo u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .push_i      (fifo_push),
        .push_data_i ({in_last, in_word}),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            last_q  <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        first_d = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
            last_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        state_d = S_RUN;
                        last_d  = fifo_head[WORD_W];
                        first_d = 1'b1;
                    end
                end
                S_RUN: begin
                    if (refill_pt) begin
                        if (!last_q && !fifo_empty) begin
                            last_d = fifo_head[WORD_W];
                        end else begin
                            state_d = S_IDLE;
                            last_d  = 1'b0;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        fifo_pop         = 1'b0;
        dp_data_rst      = 1'b0;
        dp_data_load     = 1'b0;
        dp_overflow_load = 1'b0;
        dp_count_set     = 1'b0;
        pkt_valid        = 1'b0;
        pkt_first        = 1'b0;
        pkt_last         = 1'b0;
        frame_done       = 1'b0;
        underrun         = 1'b0;
        drop_bits        = 3'd0;
        if (flush) begin
            dp_data_rst  = 1'b1;
            dp_count_set = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    dp_count_set = 1'b1;
                    if (!fifo_empty) begin
                        fifo_pop     = 1'b1;
                        dp_data_load = 1'b1;
                    end
                end
                S_RUN: begin
                    pkt_valid = 1'b1;
                    pkt_first = first_q;
                    if (refill_pt) begin
                        if (last_q) begin
                            pkt_last     = 1'b1;
                            frame_done   = 1'b1;
                            drop_bits    = 3'(CNT_W'(WORD_W - 1) - dp_count);
                            dp_data_rst  = 1'b1;
                            dp_count_set = 1'b1;
                        end else if (!fifo_empty) begin
                            fifo_pop         = 1'b1;
                            dp_data_load     = 1'b1;
                            dp_overflow_load = 1'b1;
                        end else begin
                            underrun     = 1'b1;
                            dp_data_rst  = 1'b1;
                            dp_count_set = 1'b1;
                        end
                    end
                end
                default: dp_count_set = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_data_unpack_ctrl.sv
// tb/tb_data_unpack_ctrl.sv - scoreboard bench with a behavioural bitstream model and a datapath stand-in
module tb_data_unpack_ctrl;
    import data_unpack_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] in_word = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [31:0] dp_data_in;
    logic        dp_data_rst, dp_data_load, dp_overflow_load, dp_count_set;
    logic [4:0]  dp_cnt;
    logic        pkt_valid, pkt_first, pkt_last, frame_done, underrun;
    logic [2:0]  drop_bits;

    data_unpack_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush            (flush),
        .in_word          (in_word),
        .in_valid         (in_valid),
        .in_last          (in_last),
        .in_ready         (in_ready),
        .dp_data_in       (dp_data_in),
        .dp_data_rst      (dp_data_rst),
        .dp_data_load     (dp_data_load),
        .dp_overflow_load (dp_overflow_load),
        .dp_count_set     (dp_count_set),
        .dp_count         (dp_cnt),
        .pkt_valid        (pkt_valid),
        .pkt_first        (pkt_first),
        .pkt_last         (pkt_last),
        .frame_done       (frame_done),
        .underrun         (underrun),
        .drop_bits        (drop_bits)
    );

    always #5 clk = ~clk;

    // Free-running datapath stand-in
    logic [31:0] dp_buf;
    logic [6:0]  dp_ovf;
    logic [6:0]  dp_pkt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dp_buf <= '0;
            dp_ovf <= '0;
            dp_cnt <= '0;
        end else begin
            if (dp_data_rst) begin
                dp_buf <= '0;
                dp_ovf <= '0;
            end else begin
                if (dp_data_load)     dp_buf <= dp_data_in;
                if (dp_overflow_load) dp_ovf <= dp_buf[31:25];
            end
            dp_cnt <= dp_count_set ? 5'd6 : dp_cnt + 5'd7;
        end
    end

    assign dp_pkt = 7'({dp_buf, dp_ovf} >> ({1'b0, dp_cnt} + 6'd1));

    logic [8:0]  pkt_q[$];
    logic [4:0]  evt_q[$];
    logic [31:0] fw[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    bit          sb_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame as one LSB-first bitstream: packet p is bits [7p+6:7p]; leftovers are dropped.
    function automatic void push_expected(input logic [31:0] words[$], input bit has_last);
        logic [255:0] bits;
        int n, np;
        bits = '0;
        n = words.size();
        for (int i = 0; i < n; i++) bits[32*i +: 32] = words[i];
        np = (32 * n) / 7;
        for (int p = 0; p < np; p++)
            pkt_q.push_back({p == 0, has_last && (p == np - 1), bits[7*p +: 7]});
        if (has_last) evt_q.push_back({2'b10, 3'((32 * n) % 7)});
        else          evt_q.push_back(5'b01000);
    endfunction

    always @(negedge clk) begin
        logic [8:0] pe;
        logic [4:0] ee;
        if (rst_n && sb_en) begin
            if (pkt_valid) begin
                if (pkt_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL pkt_unexpected: got 0x%0h expected none at %0t", dp_pkt, $time);
                end else begin
                    pe = pkt_q.pop_front();
                    check("pkt {first,last,data}", {pkt_first, pkt_last, dp_pkt}, pe);
                end
            end
            if (frame_done || underrun) begin
                if (evt_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL evt_unexpected: got 0x%0h expected none at %0t",
                             {frame_done, underrun, drop_bits}, $time);
                end else begin
                    ee = evt_q.pop_front();
                    check("evt {done,underrun,drop}", {frame_done, underrun, drop_bits}, ee);
                end
            end
            check("rst_load_exclusive", dp_data_rst & dp_data_load, 1'b0);
        end
    end

    task automatic send_word(input logic [31:0] w, input logic l);
        int t;
        logic rdy;
        t = 0;
        in_word = w; in_valid = 1'b1; in_last = l;
        forever begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) break;
            t++;
            if (t > 500) begin
                n_cmp++; n_fail++;
                $display("FAIL send_timeout: in_ready stuck 0 expected 1");
                break;
            end
        end
        #1;
    endtask

    task automatic send_frame(input bit has_last);
        for (int i = 0; i < fw.size(); i++) send_word(fw[i], has_last && (i == fw.size() - 1));
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((pkt_q.size() != 0 || evt_q.size() != 0) && t < 2000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 2000) begin
            n_cmp++; n_fail++;
            $display("FAIL drain_timeout: %0d pkts %0d evts left expected 0", pkt_q.size(), evt_q.size());
            pkt_q.delete();
            evt_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        int   k;
        bit   hl;

        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_count_set", dp_count_set, 1'b1);
        check("rst_outputs", {pkt_valid, pkt_first, pkt_last, frame_done, underrun, drop_bits}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_release", in_ready, 1'b1);
        @(posedge clk); #1;

        sb_en = 1'b1;
        fw.delete(); fw.push_back(32'hFFFF_FFFF);
        push_expected(fw, 1'b1); send_frame(1'b1); wait_drain();

        fw.delete(); fw.push_back(32'hF000_0000); fw.push_back(32'h0000_0001);
        push_expected(fw, 1'b1); send_frame(1'b1); wait_drain();

        fw.delete();
        for (int i = 0; i < 7; i++) fw.push_back($urandom);
        push_expected(fw, 1'b1); send_frame(1'b1); wait_drain();

        fw.delete(); fw.push_back($urandom); fw.push_back($urandom);
        push_expected(fw, 1'b0); send_frame(1'b0); wait_drain();
        repeat (4) @(negedge clk);
        check("idle_after_underrun {valid,count}", {pkt_valid, dp_cnt}, {1'b0, 5'd6});
        @(posedge clk); #1;
        fw.delete(); fw.push_back(32'h1234_5678);
        push_expected(fw, 1'b1); send_frame(1'b1); wait_drain();

        for (int f = 0; f < 30; f++) begin
            fw.delete();
            k = $urandom_range(1, 8);
            for (int i = 0; i < k; i++) fw.push_back($urandom);
            hl = ($urandom_range(0, 3) != 0);
            push_expected(fw, hl);
            send_frame(hl);
            if (!hl) wait_drain();
            else begin
                k = $urandom_range(0, 4);
                for (int c = 0; c < k; c++) begin @(posedge clk); #1; end
            end
        end
        wait_drain();

        sb_en = 1'b0;
        for (int i = 0; i < 4; i++) send_word($urandom, 1'b0);
        in_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        check("flush_cycle {valid,rdy,drst,cset,done,ur,load}",
              {pkt_valid, in_ready, dp_data_rst, dp_count_set, frame_done, underrun, dp_data_load},
              7'b0011000);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("after_flush {valid,load,rdy,count}", {pkt_valid, dp_data_load, in_ready, dp_cnt},
              {1'b0, 1'b0, 1'b1, 5'd6});
        seen = 1'b0;
        repeat (6) begin @(negedge clk); seen |= pkt_valid | dp_data_load | frame_done | underrun; end
        check("flush_fifo_empty", seen, 1'b0);
        @(posedge clk); #1;

        for (int i = 0; i < 3; i++) send_word($urandom, 1'b0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_reset_running", pkt_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset {valid,rdy,cset,done,ur,first,last,drop}",
              {pkt_valid, in_ready, dp_count_set, frame_done, underrun, pkt_first, pkt_last, drop_bits},
              10'b0010000000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin @(negedge clk); seen |= pkt_valid | dp_data_load | frame_done | underrun; end
        check("reset_discards_fifo", seen, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
